// File: rtl/lc4_div_pkg.sv
// Shared definitions for the iterative LC4 divider: FSM encoding and counter sizing.
// Pure declarations, no logic or backpressure of its own.
package lc4_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Wide enough to hold the iteration count WIDTH/BITS_PER_CYCLE itself.
  function automatic int cnt_width(input int width, input int bpc);
    return $clog2(width / bpc + 1);
  endfunction

endpackage

// File: rtl/lc4_divider_iter_if.sv
// Request/response bundle of the iterative divider; master = requester/consumer, slave = divider.
// Both directions use valid/ready; the divider raises o_ready only while idle.
interface lc4_divider_iter_if #(
  parameter int WIDTH = 16
);
  logic             i_valid;
  logic             o_ready;
  logic             i_signed;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
  logic             o_div_by_zero;
  logic             o_busy;

  modport master (
    output i_valid, i_signed, i_dividend, i_divisor, i_ready,
    input  o_ready, o_valid, o_quotient, o_remainder, o_div_by_zero, o_busy
  );

  modport slave (
    input  i_valid, i_signed, i_dividend, i_divisor, i_ready,
    output o_ready, o_valid, o_quotient, o_remainder, o_div_by_zero, o_busy
  );
endinterface

// File: rtl/lc4_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, subtract if it fits.
// Zero latency, no handshake; relies on rem_i < divisor, which the chain maintains.
module lc4_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] quo_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           fits;
  logic           unused_quo_msb;

  assign unused_quo_msb = quo_i[WIDTH-1];

  always_comb begin
    rem_sh = {rem_i, dvd_i[WIDTH-1]};
    diff   = rem_sh - {1'b0, divisor};
    // rem_sh < 2*divisor, so the borrow out of the WIDTH+1-bit subtract is exactly "does not fit".
    fits   = ~diff[WIDTH];
    rem_o  = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    dvd_o  = {dvd_i[WIDTH-2:0], 1'b0};
    quo_o  = {quo_i[WIDTH-2:0], fits};
  end
endmodule

// File: rtl/lc4_divider_iter.sv
// Iterative restoring divider, BITS_PER_CYCLE quotient bits per clock; result WIDTH/BITS_PER_CYCLE+1 cycles after accept, or 1 cycle for a zero divisor.
// Accepts only in IDLE (o_ready); the result is held in DONE until the consumer's i_ready.
module lc4_divider_iter
  import lc4_div_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic              clk,
  input logic              rst,
  lc4_divider_iter_if.slave bus
);
  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = cnt_width(WIDTH, BITS_PER_CYCLE);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quot_out_q, quot_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             dbz_q, dbz_d;

  logic             dvd_neg, dsr_neg;
  logic [WIDTH-1:0] dvd_abs, dsr_abs;
  logic [WIDTH-1:0] rem_last, dvd_last, quo_last;

  // WIDTH-bit magnitude keeps |-2^(WIDTH-1)| representable as an unsigned value.
  assign dvd_neg = bus.i_signed & bus.i_dividend[WIDTH-1];
  assign dsr_neg = bus.i_signed & bus.i_divisor[WIDTH-1];
  assign dvd_abs = dvd_neg ? -bus.i_dividend : bus.i_dividend;
  assign dsr_abs = dsr_neg ? -bus.i_divisor : bus.i_divisor;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    logic [WIDTH-1:0] rem_in, dvd_in, quo_in;
    logic [WIDTH-1:0] rem_o, dvd_o, quo_o;
    if (i == 0) begin : g_first
      assign rem_in = rem_q;
      assign dvd_in = dvd_q;
      assign quo_in = quo_q;
    end else begin : g_next
      assign rem_in = g_step[i-1].rem_o;
      assign dvd_in = g_step[i-1].dvd_o;
      assign quo_in = g_step[i-1].quo_o;
    end
    lc4_div_step #(.WIDTH(WIDTH)) u_step (
      .divisor (dsr_q),
      .rem_i   (rem_in),
      .dvd_i   (dvd_in),
      .quo_i   (quo_in),
      .rem_o   (rem_o),
      .dvd_o   (dvd_o),
      .quo_o   (quo_o)
    );
  end

  assign rem_last = g_step[BITS_PER_CYCLE-1].rem_o;
  assign dvd_last = g_step[BITS_PER_CYCLE-1].dvd_o;
  assign quo_last = g_step[BITS_PER_CYCLE-1].quo_o;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    quo_d      = quo_q;
    dsr_d      = dsr_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    dbz_d      = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          if (bus.i_divisor == '0) begin
            state_d    = ST_DONE;
            quot_out_d = '0;
            rem_out_d  = '0;
            dbz_d      = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CW'(STEPS);
            rem_d   = '0;
            dvd_d   = dvd_abs;
            quo_d   = '0;
            dsr_d   = dsr_abs;
            q_neg_d = dvd_neg ^ dsr_neg;
            r_neg_d = dvd_neg;
            dbz_d   = 1'b0;
          end
        end
      end
      ST_BUSY: begin
        rem_d = rem_last;
        dvd_d = dvd_last;
        quo_d = quo_last;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d    = ST_DONE;
          quot_out_d = q_neg_q ? -quo_last : quo_last;
          rem_out_d  = r_neg_q ? -rem_last : rem_last;
        end
      end
      ST_DONE: begin
        if (bus.i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      quo_q      <= '0;
      dsr_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      quo_q      <= quo_d;
      dsr_q      <= dsr_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.o_ready       = (state_q == ST_IDLE);
  assign bus.o_valid       = (state_q == ST_DONE);
  assign bus.o_busy        = (state_q != ST_IDLE);
  assign bus.o_quotient    = quot_out_q;
  assign bus.o_remainder   = rem_out_q;
  assign bus.o_div_by_zero = dbz_q;
endmodule

// File: tb/tb_lc4_divider_iter.sv
// Scoreboard bench: two divider instances (1 and 4 bits per cycle) driven in parallel,
// expectations from directed constants and an integer-arithmetic reference model.
module tb_lc4_divider_iter;
  localparam int W     = 16;
  localparam int NRAND = 1200;

  typedef struct {
    logic [15:0] a, b, q, r;
    logic        s, z;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [15:0] a, b;
    logic        s;
    logic [15:0] q, r;
    logic        z;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]       rst_v, in_vld, in_sgn, in_rdy;
  logic [1:0][15:0] in_a, in_b;
  logic [1:0]       o_vld_w, o_rdy_w, o_busy_w, o_z_w;
  logic [1:0][15:0] o_q_w, o_r_w;

  exp_t sb_q [2][$];
  vec_t dir [12];
  int   checks = 0;
  int   errors = 0;
  bit [1:0] tmo;
  bit   fin_req = 0;
  bit   fin_done = 0;
  bit   rst_prev [2];
  bit   seen [2];
  exp_t e;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int BPC = (g == 0) ? 1 : 4;
    lc4_divider_iter_if #(.WIDTH(W)) bus ();
    assign bus.i_valid    = in_vld[g];
    assign bus.i_signed   = in_sgn[g];
    assign bus.i_dividend = in_a[g];
    assign bus.i_divisor  = in_b[g];
    assign bus.i_ready    = in_rdy[g];
    assign o_vld_w[g]     = bus.o_valid;
    assign o_rdy_w[g]     = bus.o_ready;
    assign o_busy_w[g]    = bus.o_busy;
    assign o_z_w[g]       = bus.o_div_by_zero;
    assign o_q_w[g]       = bus.o_quotient;
    assign o_r_w[g]       = bus.o_remainder;
    lc4_divider_iter #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) u_dut (
      .clk (clk),
      .rst (rst_v[g]),
      .bus (bus)
    );
  end

  function automatic exp_t ref_div(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t r;
    int   qa, ra;
    r.a = a; r.b = b; r.s = s; r.acc = 0; r.lat = 0;
    if (b == 16'h0) begin
      r.q = 16'h0; r.r = 16'h0; r.z = 1'b1;
    end else begin
      r.z = 1'b0;
      if (s) begin
        qa = int'($signed(a)) / int'($signed(b));
        ra = int'($signed(a)) % int'($signed(b));
      end else begin
        qa = int'(a) / int'(b);
        ra = int'(a) % int'(b);
      end
      r.q = qa[15:0];
      r.r = ra[15:0];
    end
    return r;
  endfunction

  task automatic chk(input int d, input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h want %h at t=%0t", nm, d, act, exp, $time);
    end
  endtask

  // Consumer: random backpressure on the result side.
  always @(posedge clk) begin
    #1;
    in_rdy[0] = ($urandom_range(0, 3) != 0);
    in_rdy[1] = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares every valid cycle against the queue head, pops on handshake.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_v[d]) begin
        if (rst_prev[d])
          chk(d, "reset_state",
              48'({o_vld_w[d], o_rdy_w[d], o_busy_w[d], o_z_w[d], o_q_w[d], o_r_w[d]}),
              48'({1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0}));
        sb_q[d].delete();
        seen[d] = 1'b0;
      end else if (o_vld_w[d]) begin
        if (sb_q[d].size() == 0) begin
          chk(d, "unexpected_valid", 48'(o_vld_w[d]), 48'(0));
        end else begin
          e = sb_q[d][0];
          if (!seen[d]) begin
            chk(d, "latency", 48'(cyc - e.acc + 1), 48'(e.lat));
            seen[d] = 1'b1;
          end
          chk(d, "result_zqr", 48'({o_z_w[d], o_q_w[d], o_r_w[d]}), 48'({e.z, e.q, e.r}));
          chk(d, "ready_busy_in_done", 48'({o_rdy_w[d], o_busy_w[d]}), 48'(2'b01));
          if (in_rdy[d]) begin
            void'(sb_q[d].pop_front());
            seen[d] = 1'b0;
          end
        end
      end
      rst_prev[d] = rst_v[d];
    end
    if (fin_req && !fin_done) begin
      for (int d = 0; d < 2; d++)
        chk(d, "drain_and_timeout", 48'(sb_q[d].size()) + 48'(tmo[d]), 48'(0));
      fin_done = 1'b1;
    end
  end

  task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b, input logic s,
                       input bit use_ref, input logic [15:0] q, input logic [15:0] r, input logic z);
    exp_t x;
    int   budget;
    if (use_ref) begin
      x = ref_div(a, b, s);
    end else begin
      x.a = a; x.b = b; x.s = s; x.q = q; x.r = r; x.z = z;
    end
    x.lat = x.z ? 1 : ((d == 0) ? 17 : 5);
    in_a[d] = a; in_b[d] = b; in_sgn[d] = s; in_vld[d] = 1'b1;
    budget = 200;
    while (!o_rdy_w[d] && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!o_rdy_w[d]) begin
      tmo[d] = 1'b1;
      in_vld[d] = 1'b0;
      return;
    end
    x.acc = cyc + 1;
    sb_q[d].push_back(x);
    @(posedge clk); #1;
    in_vld[d] = 1'b0;
    in_a[d]   = 16'($urandom);
    in_b[d]   = 16'($urandom);
    in_sgn[d] = 1'($urandom);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input int d);
    logic [15:0] a, b;
    logic        s;
    foreach (dir[i]) issue(d, dir[i].a, dir[i].b, dir[i].s, 1'b0, dir[i].q, dir[i].r, dir[i].z);
    // Abort an in-flight 1000/3, then repeat it cleanly.
    issue(d, 16'd1000, 16'd3, 1'b0, 1'b0, 16'd333, 16'd1, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst_v[d] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_v[d] = 1'b0;
    issue(d, 16'd1000, 16'd3, 1'b0, 1'b0, 16'd333, 16'd1, 1'b0);
    repeat (NRAND) begin
      a = 16'($urandom);
      if ($urandom_range(0, 15) == 0) a = 16'h8000;
      case ($urandom_range(0, 15))
        0:       b = 16'h0;
        1:       b = 16'hFFFF;
        2, 3, 4: b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      s = 1'($urandom);
      issue(d, a, b, s, 1'b1, 16'h0, 16'h0, 1'b0);
    end
  endtask

  initial begin
    rst_v  = 2'b11;
    in_vld = 2'b00;
    in_sgn = 2'b00;
    in_a   = '0;
    in_b   = '0;
    tmo    = 2'b00;
    dir = '{
      '{16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0},
      '{16'h1234, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1},
      '{16'h1234, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1},
      '{16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0},
      '{16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0},
      '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0},
      '{16'h8000, 16'h0001, 1'b1, 16'h8000, 16'h0000, 1'b0},
      '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 16'h0000, 1'b0},
      '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0},
      '{16'd5,    16'd9,    1'b0, 16'd0,    16'd5,    1'b0},
      '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 1'b0},
      '{16'hBEEF, 16'h0013, 1'b0, 16'd2572,  16'd11,  1'b0}
    };
    repeat (3) begin @(posedge clk); #1; end
    rst_v = 2'b00;
    fork
      run(0);
      run(1);
    join
    for (int i = 0; i < 3000 && (sb_q[0].size() != 0 || sb_q[1].size() != 0); i++) begin
      @(posedge clk); #1;
    end
    fin_req = 1'b1;
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
